// File: rtl/tournament_selector.sv
// Purpose: runs one tournament selection by reading TOUR_SIZE randomly indexed
//          chromosomes and returning the fittest one (chromosome, fitness, index).
// Latency: done pulses 2*TOUR_SIZE+1 cycles after start is sampled in IDLE.
// Backpressure: none; start is ignored while busy and is never queued.
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   start            request a tournament (sampled in IDLE only)
//   rand_idx         candidate index from the LFSR
//   rand_ack         rand_idx consumed this cycle (LFSR advances)
//   mem_rBarw        memory read/write select, constant read
//   mem_address      rand_idx % COUNT, zero-extended
//   mem_data_out     chromosome read from memory (combinational)
//   mem_fitness_out  fitness read from memory (combinational)
//   busy             tournament in progress
//   done             one-cycle pulse, winner_* valid
//   winner_data      winning chromosome
//   winner_fitness   winning fitness
//   winner_index     winning memory index
module tournament_selector #(
  parameter int COUNT      = 32,
  parameter int DATA_WIDTH = 19,
  parameter int ADDR_WIDTH = 5,
  parameter int TOUR_SIZE  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] rand_idx,
  output logic                  rand_ack,
  output logic                  mem_rBarw,
  output logic [COUNT-1:0]      mem_address,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic [63:0]           mem_fitness_out,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] winner_data,
  output logic [63:0]           winner_fitness,
  output logic [ADDR_WIDTH-1:0] winner_index
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_READ,
    S_DONE
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] cur_idx;

  // Running best of the tournament; only copied to winner_* on the last READ.
  logic [DATA_WIDTH-1:0] best_data;
  logic [63:0]           best_fitness;
  logic [ADDR_WIDTH-1:0] best_index;

  logic [31:0]           idx_wide;
  logic                  take;
  logic                  last;
  logic [DATA_WIDTH-1:0] nxt_data;
  logic [63:0]           nxt_fitness;
  logic [ADDR_WIDTH-1:0] nxt_index;

  // Modulo handles COUNT that is not a power of two and indices >= COUNT.
  assign idx_wide = 32'(rand_idx) % 32'(COUNT);

  // First candidate always seeds the best; later ones must be strictly fitter,
  // so ties keep the earlier candidate.
  assign take        = (cnt == '0) || (mem_fitness_out > best_fitness);
  assign last        = (cnt == ADDR_WIDTH'(TOUR_SIZE - 1));
  assign nxt_data    = take ? mem_data_out    : best_data;
  assign nxt_fitness = take ? mem_fitness_out : best_fitness;
  assign nxt_index   = take ? cur_idx         : best_index;

  assign rand_ack  = (state == S_LOAD);
  assign busy      = (state != S_IDLE);
  assign mem_rBarw = 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      cur_idx        <= '0;
      mem_address    <= '0;
      done           <= 1'b0;
      best_data      <= '0;
      best_fitness   <= '0;
      best_index     <= '0;
      winner_data    <= '0;
      winner_fitness <= '0;
      winner_index   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt   <= '0;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          mem_address <= COUNT'(idx_wide);
          cur_idx     <= idx_wide[ADDR_WIDTH-1:0];
          state       <= S_READ;
        end
        S_READ: begin
          best_data    <= nxt_data;
          best_fitness <= nxt_fitness;
          best_index   <= nxt_index;
          if (last) begin
            winner_data    <= nxt_data;
            winner_fitness <= nxt_fitness;
            winner_index   <= nxt_index;
            done           <= 1'b1;
            state          <= S_DONE;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= S_LOAD;
          end
        end
        S_DONE: begin
          // Always pass through IDLE; a start seen here is dropped.
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tournament_selector.sv
// Purpose: directed self-checking bench for tournament_selector.
// Latency: checks done timing of 2*TOUR_SIZE+1 cycles for TOUR_SIZE 4 and 1.
// Backpressure: checks that start pulses during busy/DONE are ignored.
module tb_tournament_selector;

  localparam int COUNT = 32;
  localparam int DW    = 19;
  localparam int AW    = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: TOUR_SIZE=4, 6-bit indices so wrap can be exercised
  logic              a_rst, a_start, a_rand_ack, a_rBarw, a_busy, a_done;
  logic [AW-1:0]     a_rand_idx, a_widx;
  logic [COUNT-1:0]  a_addr;
  logic [DW-1:0]     a_mdata, a_wdata;
  logic [63:0]       a_mfit, a_wfit;

  // DUT B: TOUR_SIZE=1
  logic              b_rst, b_start, b_rand_ack, b_rBarw, b_busy, b_done;
  logic [AW-1:0]     b_rand_idx, b_widx;
  logic [COUNT-1:0]  b_addr;
  logic [DW-1:0]     b_mdata, b_wdata;
  logic [63:0]       b_mfit, b_wfit;

  logic [DW-1:0] mem_data [COUNT];
  logic [63:0]   mem_fit  [COUNT];

  assign a_mdata = mem_data[a_addr[4:0]];
  assign a_mfit  = mem_fit[a_addr[4:0]];
  assign b_mdata = mem_data[b_addr[4:0]];
  assign b_mfit  = mem_fit[b_addr[4:0]];

  tournament_selector #(.COUNT(COUNT), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TOUR_SIZE(4)) dut_a (
    .clk(clk), .rst(a_rst), .start(a_start), .rand_idx(a_rand_idx), .rand_ack(a_rand_ack),
    .mem_rBarw(a_rBarw), .mem_address(a_addr), .mem_data_out(a_mdata), .mem_fitness_out(a_mfit),
    .busy(a_busy), .done(a_done), .winner_data(a_wdata), .winner_fitness(a_wfit),
    .winner_index(a_widx)
  );

  tournament_selector #(.COUNT(COUNT), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TOUR_SIZE(1)) dut_b (
    .clk(clk), .rst(b_rst), .start(b_start), .rand_idx(b_rand_idx), .rand_ack(b_rand_ack),
    .mem_rBarw(b_rBarw), .mem_address(b_addr), .mem_data_out(b_mdata), .mem_fitness_out(b_mfit),
    .busy(b_busy), .done(b_done), .winner_data(b_wdata), .winner_fitness(b_wfit),
    .winner_index(b_widx)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Per-run records for DUT A
  logic [AW-1:0]    seq_a [4];
  logic             busy_log [64];
  logic [AW-1:0]    widx_log [64];
  logic [63:0]      wfit_log [64];
  logic [COUNT-1:0] addr_log [64];
  int               ack_cnt, done_cnt, done_cyc;
  logic [AW-1:0]    done_idx;
  logic [63:0]      done_fit;
  logic [DW-1:0]    done_data;

  // Starts a tournament on DUT A (start sampled at edge E0) and records outputs
  // at the falling edge of cycles 1..ncyc after E0. rand_idx is presented from
  // seq_a whenever rand_ack is seen.
  task automatic run_a(input int rst_cycle, input int s1, input int s2, input int ncyc);
    int ptr;
    ptr = 0; ack_cnt = 0; done_cnt = 0; done_cyc = -1;
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= ncyc; k++) begin
      busy_log[k] = a_busy;
      widx_log[k] = a_widx;
      wfit_log[k] = a_wfit;
      addr_log[k] = a_addr;
      if (a_rand_ack) begin
        ack_cnt++;
        a_rand_idx = seq_a[ptr % 4];
        ptr++;
      end
      if (a_done) begin
        done_cnt++;
        done_cyc  = k;
        done_idx  = a_widx;
        done_fit  = a_wfit;
        done_data = a_wdata;
      end
      a_start = (k == s1) || (k == s2);
      a_rst   = (k == rst_cycle);
      @(negedge clk);
    end
    a_start = 1'b0;
    a_rst   = 1'b0;
  endtask

  task automatic test_reset;
    a_rst = 1'b1; b_rst = 1'b1; a_start = 1'b0; b_start = 1'b0;
    a_rand_idx = '0; b_rand_idx = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({a_busy, a_done, a_rand_ack} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: busy/done/ack=%b expected 000", {a_busy, a_done, a_rand_ack});
    end
    n_checks++;
    if (a_addr !== '0 || a_widx !== '0 || a_wfit !== '0 || a_wdata !== '0) begin
      n_fail++; $display("FAIL reset_regs: addr=%0d idx=%0d fit=%0d data=%0d expected all 0",
                         a_addr, a_widx, a_wfit, a_wdata);
    end
    n_checks++;
    if (a_rBarw !== 1'b1 || b_rBarw !== 1'b1) begin
      n_fail++; $display("FAIL reset_rbarw: a=%b b=%b expected 1", a_rBarw, b_rBarw);
    end
    n_checks++;
    if ({b_busy, b_done, b_widx} !== '0) begin
      n_fail++; $display("FAIL reset_b: busy=%b done=%b idx=%0d expected 0", b_busy, b_done, b_widx);
    end
    a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    mem_fit[3] = 64'd10; mem_fit[8] = 64'd50; mem_fit[12] = 64'd30; mem_fit[20] = 64'd40;
    seq_a[0] = 6'd3; seq_a[1] = 6'd8; seq_a[2] = 6'd12; seq_a[3] = 6'd20;
    run_a(-1, -1, -1, 14);
    n_checks++;
    if (done_cyc !== 9 || done_cnt !== 1) begin
      n_fail++; $display("FAIL basic_done: cycle=%0d count=%0d expected cycle 9 count 1", done_cyc, done_cnt);
    end
    n_checks++;
    if (done_idx !== 6'd8 || done_fit !== 64'd50 || done_data !== mem_data[8]) begin
      n_fail++; $display("FAIL basic_winner: idx=%0d fit=%0d data=%0h expected 8 50 %0h",
                         done_idx, done_fit, done_data, mem_data[8]);
    end
    n_checks++;
    if (ack_cnt !== 4) begin
      n_fail++; $display("FAIL basic_ack: rand_ack cycles=%0d expected 4", ack_cnt);
    end
    n_checks++;
    if (busy_log[1] !== 1'b1 || busy_log[9] !== 1'b1 || busy_log[10] !== 1'b0) begin
      n_fail++; $display("FAIL basic_busy: c1=%b c9=%b c10=%b expected 1 1 0",
                         busy_log[1], busy_log[9], busy_log[10]);
    end
    n_checks++;
    if (widx_log[8] !== 6'd0 || widx_log[14] !== 6'd8) begin
      n_fail++; $display("FAIL basic_hold: idx c8=%0d c14=%0d expected 0 8", widx_log[8], widx_log[14]);
    end
  endtask

  task automatic test_tie;
    mem_fit[5] = 64'd77; mem_fit[9] = 64'd77; mem_fit[1] = 64'd1; mem_fit[2] = 64'd2;
    seq_a[0] = 6'd5; seq_a[1] = 6'd9; seq_a[2] = 6'd1; seq_a[3] = 6'd2;
    run_a(-1, -1, -1, 12);
    n_checks++;
    if (done_idx !== 6'd5 || done_fit !== 64'd77) begin
      n_fail++; $display("FAIL tie_winner: idx=%0d fit=%0d expected 5 77", done_idx, done_fit);
    end
  endtask

  task automatic test_wrap;
    seq_a[0] = 6'd37; seq_a[1] = 6'd1; seq_a[2] = 6'd2; seq_a[3] = 6'd3;
    run_a(-1, -1, -1, 12);
    n_checks++;
    if (addr_log[2] !== COUNT'(5)) begin
      n_fail++; $display("FAIL wrap_addr: mem_address=%0d expected 5", addr_log[2]);
    end
    n_checks++;
    if (done_idx !== 6'd5 || done_data !== mem_data[5]) begin
      n_fail++; $display("FAIL wrap_winner: idx=%0d data=%0h expected 5 %0h", done_idx, done_data, mem_data[5]);
    end
  endtask

  task automatic test_start_ignored;
    seq_a[0] = 6'd3; seq_a[1] = 6'd8; seq_a[2] = 6'd12; seq_a[3] = 6'd20;
    run_a(-1, 3, 9, 24);
    n_checks++;
    if (done_cnt !== 1 || done_cyc !== 9) begin
      n_fail++; $display("FAIL ignore_done: count=%0d cycle=%0d expected 1 9", done_cnt, done_cyc);
    end
    n_checks++;
    if (busy_log[10] !== 1'b0 || busy_log[11] !== 1'b0 || ack_cnt !== 4) begin
      n_fail++; $display("FAIL ignore_busy: c10=%b c11=%b acks=%0d expected 0 0 4",
                         busy_log[10], busy_log[11], ack_cnt);
    end
    run_a(-1, -1, -1, 12);
    n_checks++;
    if (done_cyc !== 9 || done_idx !== 6'd8 || done_fit !== 64'd50) begin
      n_fail++; $display("FAIL ignore_rerun: cycle=%0d idx=%0d fit=%0d expected 9 8 50",
                         done_cyc, done_idx, done_fit);
    end
  endtask

  task automatic test_mid_reset;
    run_a(4, -1, -1, 25);
    n_checks++;
    if (widx_log[3] !== 6'd8) begin
      n_fail++; $display("FAIL midrst_before: idx=%0d expected 8", widx_log[3]);
    end
    n_checks++;
    if (busy_log[5] !== 1'b0 || widx_log[5] !== 6'd0 || wfit_log[5] !== 64'd0) begin
      n_fail++; $display("FAIL midrst_state: busy=%b idx=%0d fit=%0d expected 0 0 0",
                         busy_log[5], widx_log[5], wfit_log[5]);
    end
    n_checks++;
    if (done_cnt !== 0 || busy_log[25] !== 1'b0) begin
      n_fail++; $display("FAIL midrst_nodone: dones=%0d busy=%b expected 0 0", done_cnt, busy_log[25]);
    end
  endtask

  task automatic test_max_fitness;
    int bcyc;
    mem_fit[0] = 64'd0; mem_fit[1] = 64'd0; mem_fit[2] = 64'd0;
    mem_fit[31] = 64'hFFFF_FFFF_FFFF_FFFF;
    seq_a[0] = 6'd0; seq_a[1] = 6'd1; seq_a[2] = 6'd2; seq_a[3] = 6'd31;
    run_a(-1, -1, -1, 12);
    n_checks++;
    if (done_idx !== 6'd31 || done_fit !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_fail++; $display("FAIL max_winner: idx=%0d fit=%0h expected 31 ffffffffffffffff", done_idx, done_fit);
    end
    // TOUR_SIZE=1 instance
    bcyc = -1;
    b_rand_idx = 6'd17;
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (b_done && bcyc < 0) bcyc = k;
      @(negedge clk);
    end
    n_checks++;
    if (bcyc !== 3) begin
      n_fail++; $display("FAIL t1_latency: done cycle=%0d expected 3", bcyc);
    end
    n_checks++;
    if (b_widx !== 6'd17 || b_wfit !== mem_fit[17] || b_wdata !== mem_data[17]) begin
      n_fail++; $display("FAIL t1_winner: idx=%0d fit=%0d data=%0h expected 17 %0d %0h",
                         b_widx, b_wfit, b_wdata, mem_fit[17], mem_data[17]);
    end
  endtask

  initial begin
    for (int i = 0; i < COUNT; i++) begin
      mem_data[i] = DW'(i * 4099 + 3);
      mem_fit[i]  = 64'(i);
    end
    test_reset();
    test_basic();
    test_tie();
    test_wrap();
    test_start_ignored();
    test_mid_reset();
    test_max_fitness();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
